// File: rtl/dpram_arb_pkg.sv
// Shared types and constants for the dual-port RAM arbiter: requester ids,
// port classes and the starvation counter width.
package dpram_arb_pkg;

   typedef enum logic {
      REQ_A = 1'b0,
      REQ_B = 1'b1
   } req_id_t;

   typedef enum logic {
      PORT_WR = 1'b0,
      PORT_RD = 1'b1
   } port_cls_t;

   localparam int STARVE_CNT_W = 8;

   // A request's we bit alone decides which RAM port it competes for.
   function automatic port_cls_t port_of(input logic we);
      return we ? PORT_WR : PORT_RD;
   endfunction

endpackage

// File: rtl/arb2_starve.sv
// Two-way arbiter for one RAM port: round-robin or A-priority with a
// saturating starvation counter that forces B through after a bounded wait.
module arb2_starve
   import dpram_arb_pkg::*;
#(
   parameter bit          PRIO_A       = 1'b1,
   parameter int unsigned STARVE_LIMIT = 7
) (
   input  logic clk,
   input  logic reset,
   input  logic req_a,
   input  logic req_b,
   output logic gnt_a,
   output logic gnt_b
);

   localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

   req_id_t                 last_q, last_d;
   logic [STARVE_CNT_W-1:0] starve_q, starve_d;

   always_comb begin
      gnt_a    = 1'b0;
      gnt_b    = 1'b0;
      last_d   = last_q;
      starve_d = '0;

      if (req_a && req_b) begin
         if (PRIO_A) begin
            if (starve_q >= LIMIT) gnt_b = 1'b1;
            else                   gnt_a = 1'b1;
         end else begin
            // Round-robin: whoever was not served last time wins.
            if (last_q == REQ_A) gnt_b = 1'b1;
            else                 gnt_a = 1'b1;
         end
      end else begin
         gnt_a = req_a;
         gnt_b = req_b;
      end

      if (gnt_a)      last_d = REQ_A;
      else if (gnt_b) last_d = REQ_B;

      if (req_b && !gnt_b) begin
         starve_d = (starve_q >= LIMIT) ? LIMIT : starve_q + STARVE_CNT_W'(1);
      end
   end

   // Reset leaves the pointer on B so the first contended grant goes to A.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_q   <= REQ_B;
         starve_q <= '0;
      end else begin
         last_q   <= last_d;
         starve_q <= starve_d;
      end
   end

endmodule

// File: rtl/dpram_port_arbiter.sv
// Shares one dpram between requester A (CPU) and B (display/loader): the write
// and read ports are arbitrated independently; read data returns one cycle later.
module dpram_port_arbiter
   import dpram_arb_pkg::*;
#(
   parameter int          ADDR_WIDTH   = 10,
   parameter int          DATA_WIDTH   = 8,
   parameter bit          PRIO_A       = 1'b1,
   parameter int unsigned STARVE_LIMIT = 7
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_a,
   input  logic                  req_b,
   input  logic                  we_a,
   input  logic                  we_b,
   input  logic [ADDR_WIDTH-1:0] addr_a,
   input  logic [ADDR_WIDTH-1:0] addr_b,
   input  logic [DATA_WIDTH-1:0] wdata_a,
   input  logic [DATA_WIDTH-1:0] wdata_b,
   output logic                  gnt_a,
   output logic                  gnt_b,
   output logic                  rvalid_a,
   output logic                  rvalid_b,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  ram_we,
   output logic                  ram_re,
   output logic [ADDR_WIDTH-1:0] ram_w_addr,
   output logic [ADDR_WIDTH-1:0] ram_r_addr,
   output logic [DATA_WIDTH-1:0] ram_w_data,
   input  logic [DATA_WIDTH-1:0] ram_r_data
);

   // Handshake: a requester holds req/we/addr/wdata until it sees gnt in the
   // same cycle; that cycle is the transfer. A granted read answers with a
   // single-cycle rvalid_<x> pulse on the next cycle, rdata qualified by it.

   logic wr_req_a, wr_req_b, rd_req_a, rd_req_b;
   logic wr_gnt_a, wr_gnt_b, rd_gnt_a, rd_gnt_b;
   logic wr_take_a, wr_take_b, rd_take_a, rd_take_b;
   logic rvalid_a_q, rvalid_a_d, rvalid_b_q, rvalid_b_d;

   always_comb begin
      wr_req_a = req_a && (port_of(we_a) == PORT_WR);
      wr_req_b = req_b && (port_of(we_b) == PORT_WR);
      rd_req_a = req_a && (port_of(we_a) == PORT_RD);
      rd_req_b = req_b && (port_of(we_b) == PORT_RD);
   end

   arb2_starve #(
      .PRIO_A       (PRIO_A),
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_wr_arb (
      .clk   (clk),
      .reset (reset),
      .req_a (wr_req_a),
      .req_b (wr_req_b),
      .gnt_a (wr_gnt_a),
      .gnt_b (wr_gnt_b)
   );

   arb2_starve #(
      .PRIO_A       (PRIO_A),
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_rd_arb (
      .clk   (clk),
      .reset (reset),
      .req_a (rd_req_a),
      .req_b (rd_req_b),
      .gnt_a (rd_gnt_a),
      .gnt_b (rd_gnt_b)
   );

   // Grants seen while reset is high are discarded, so nothing reaches the RAM.
   always_comb begin
      wr_take_a  = wr_gnt_a && !reset;
      wr_take_b  = wr_gnt_b && !reset;
      rd_take_a  = rd_gnt_a && !reset;
      rd_take_b  = rd_gnt_b && !reset;

      gnt_a      = wr_take_a || rd_take_a;
      gnt_b      = wr_take_b || rd_take_b;

      ram_we     = wr_take_a || wr_take_b;
      ram_w_addr = wr_take_b ? addr_b  : addr_a;
      ram_w_data = wr_take_b ? wdata_b : wdata_a;
      ram_re     = rd_take_a || rd_take_b;
      ram_r_addr = rd_take_b ? addr_b  : addr_a;

      rvalid_a_d = rd_take_a;
      rvalid_b_d = rd_take_b;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rvalid_a_q <= 1'b0;
         rvalid_b_q <= 1'b0;
      end else begin
         rvalid_a_q <= rvalid_a_d;
         rvalid_b_q <= rvalid_b_d;
      end
   end

   // The dpram output register already supplies the one-cycle latency.
   always_comb begin
      rvalid_a = rvalid_a_q;
      rvalid_b = rvalid_b_q;
      rdata    = (rvalid_a_q || rvalid_b_q) ? ram_r_data : '0;
   end

endmodule
